// File: rtl/divider_pkg.sv
// Shared width definitions for the ALU blocks, plus a sizing helper for the divider.
package divider_pkg;

  localparam int DATA_WIDTH = 32;

  // Counter width wide enough to hold the full iteration count WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, compare against the divisor and subtract when it fits.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_dvd,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_dvd
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_dvs_ext;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // The compare runs at WIDTH+1 bits; the difference only matters when it fits,
  // and then it is below the divisor, so WIDTH bits hold it exactly.
  assign w_shift   = {i_rem, i_dvd[WIDTH-1]};
  assign w_dvs_ext = {1'b0, i_dvs};
  assign w_ge      = (w_shift >= w_dvs_ext);
  assign w_diff    = w_shift[WIDTH-1:0] - i_dvs;
  assign o_rem     = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign o_dvd     = {i_dvd[WIDTH-2:0], w_ge};

endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first,
// with a one-cycle shortcut for a zero divisor.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic             r_zero;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_dvd_next;

  assign w_accept = enable && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_dvd (r_dvd),
    .i_dvs (r_dvs),
    .o_rem (w_rem_next),
    .o_dvd (w_dvd_next)
  );

  // A zero divisor loads a count of one, so it finishes on the very next edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      r_busy <= (r_state == S_RUN) && !w_last;
      if (w_accept) begin
        r_state <= S_RUN;
        r_cnt   <= (op2 == '0) ? CW'(1) : CW'(WIDTH);
      end else if (w_last) begin
        r_state <= S_DONE;
        r_cnt   <= r_cnt - CW'(1);
      end else if (r_state == S_RUN) begin
        r_cnt   <= r_cnt - CW'(1);
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_dvd  <= op1;
      r_dvs  <= op2;
      r_rem  <= '0;
      r_zero <= (op2 == '0);
    end else if ((r_state == S_RUN) && !r_zero) begin
      r_dvd  <= w_dvd_next;
      r_rem  <= w_rem_next;
    end
  end

  // Results only change on the finishing edge, so they stay put across later starts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_dbz <= 1'b0;
    end else if (w_last) begin
      if (r_zero) begin
        r_quotient  <= '1;
        r_remainder <= r_dvd;
        r_dbz       <= 1'b1;
      end else begin
        r_quotient  <= w_dvd_next;
        r_remainder <= w_rem_next;
        r_dbz       <= 1'b0;
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the divider: expected results are queued when an operation
// is started and compared when done is seen.
module tb_divider;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic         clock;
  logic         reset;
  logic         enable;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   donePulses = 0;
  int   pulseMark;

  divider #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .op1         (op1),
    .op2         (op2),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (done === 1'b1) donePulses <= donePulses + 1;
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the following rising edge is the acceptance edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.q   = (b == '0) ? '1 : a / b;
    e.r   = (b == '0) ? a : a % b;
    e.dbz = (b == '0);
    sb.push_back(e);
    op1    = a;
    op2    = b;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int expLat, input int expBusy);
    int   n;
    int   busyCnt;
    exp_t e;
    n = 0;
    busyCnt = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) busyCnt++;
      @(negedge clock);
      n++;
    end
    checkOutput({tag, "_done_seen"}, W'(done), W'(1));
    checkOutput({tag, "_latency"}, W'(n), W'(expLat));
    checkOutput({tag, "_busy_cycles"}, W'(busyCnt), W'(expBusy));
    checkOutput({tag, "_sb_nonempty"}, W'(sb.size() != 0), W'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_quotient"}, quotient, e.q);
      checkOutput({tag, "_remainder"}, remainder, e.r);
      checkOutput({tag, "_div_by_zero"}, W'(div_by_zero), W'(e.dbz));
    end
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_quotient"}, quotient, '0);
    checkOutput({tag, "_remainder"}, remainder, '0);
    checkOutput({tag, "_busy"}, W'(busy), '0);
    checkOutput({tag, "_done"}, W'(done), '0);
    checkOutput({tag, "_div_by_zero"}, W'(div_by_zero), '0);
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    op1    = '0;
    op2    = '0;
    repeat (2) @(negedge clock);
    checkCleared("reset");
    reset = 1'b1;
    @(negedge clock);

    // Basic 100/7 with latency, busy length and one-cycle done
    applyStimulus(32'd100, 32'd7);
    waitDone("d100_7", 32, 31);
    @(negedge clock);
    checkOutput("d100_7_done_pulse_width", W'(done), '0);
    checkOutput("d100_7_q_held", quotient, 32'd14);

    @(negedge clock);
    applyStimulus(32'hFFFF_FFFF, 32'd1);
    waitDone("dmax_1", 32, 31);

    @(negedge clock);
    applyStimulus(32'd3, 32'd10);
    waitDone("d3_10", 32, 31);

    // Divide by zero, held flag, then cleared by the next start
    @(negedge clock);
    applyStimulus(32'd5, 32'd0);
    waitDone("d5_0", 1, 0);
    repeat (3) @(negedge clock);
    checkOutput("d5_0_dbz_held", W'(div_by_zero), W'(1));
    checkOutput("d5_0_q_held", quotient, 32'hFFFF_FFFF);
    applyStimulus(32'd9, 32'd3);
    checkOutput("d9_3_dbz_cleared", W'(div_by_zero), '0);
    waitDone("d9_3", 32, 31);

    // Enable re-pulsed mid-run must be ignored
    @(negedge clock);
    pulseMark = donePulses;
    applyStimulus(32'd100, 32'd7);
    repeat (10) @(negedge clock);
    op1    = 32'd50;
    op2    = 32'd5;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    waitDone("repulse", 21, 21);
    repeat (40) @(negedge clock);
    checkOutput("repulse_done_count", W'(donePulses - pulseMark), W'(1));

    // Reset mid-run aborts; start on the first edge after release
    applyStimulus(32'd100, 32'd7);
    repeat (15) @(negedge clock);
    reset = 1'b0;
    void'(sb.pop_back());
    #1;
    checkCleared("abort");
    pulseMark = donePulses;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    applyStimulus(32'd64, 32'd8);
    waitDone("d64_8", 32, 31);
    checkOutput("abort_no_done", W'(donePulses - pulseMark), W'(0));

    // Back-to-back: enable held in the DONE cycle
    @(negedge clock);
    applyStimulus(32'd100, 32'd7);
    waitDone("b2b_first", 32, 31);
    applyStimulus(32'd81, 32'd9);
    waitDone("b2b_second", 32, 31);

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
